// File: rtl/soc_it_master_request_arbiter.sv
// ---------------------------------------------------------------------------
// soc_it_master_request_arbiter
//
// Shares the single SoC-IT master request port among NUM_REQ on-chip
// requesters (matching engines, descriptor fetchers, ...). A round-robin
// arbiter picks one pending request, registers its fields onto the master
// request port and holds them until SoC-IT acknowledges with a tag. A
// tag-ownership table records which requester owns each in-flight tag so
// completions and their error codes are routed back to the issuer.
//
// Parameters
//   NUM_REQ          number of requesters (2..8)
//   MAX_OUTSTANDING  global cap on in-flight requests (1..16)
//
// Ports
//   clk                        single clock (same domain as master_clk)
//   rst                        asynchronous reset, active low
//   req_valid[i]               requester i has a request pending
//   req_type/flow/local_address/length
//                              packed per-requester fields, slice i = req i
//   req_ack[i]                 one-cycle pulse: request of i accepted
//   req_tag                    tag assigned, valid with any req_ack bit
//   cpl_valid[i]               one-cycle pulse: completion for requester i
//   cpl_tag / cpl_error        completed tag and its error code
//   master_request             request to SoC-IT, held until ack
//   master_request_type/flow/local_address/length
//                              registered fields of the granted request
//   master_request_ack         SoC-IT accepts, tag valid this cycle
//   master_request_complete    completion pulse, tag identifies request
//   master_request_tag         tag from SoC-IT (ack or completion)
//   master_request_error       error code, valid with complete
//   outstanding                current number of in-flight requests
//   err_dup_tag                sticky: ack returned a tag already in use
//   err_unknown_tag            sticky: completion for a tag not in use
// ---------------------------------------------------------------------------
module soc_it_master_request_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [4*NUM_REQ-1:0]    req_type,
    input  logic [10*NUM_REQ-1:0]   req_flow,
    input  logic [64*NUM_REQ-1:0]   req_local_address,
    input  logic [36*NUM_REQ-1:0]   req_length,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [3:0]              req_tag,
    output logic [NUM_REQ-1:0]      cpl_valid,
    output logic [3:0]              cpl_tag,
    output logic [6:0]              cpl_error,
    output logic                    master_request,
    output logic [3:0]              master_request_type,
    output logic [9:0]              master_request_flow,
    output logic [63:0]             master_request_local_address,
    output logic [35:0]             master_request_length,
    input  logic                    master_request_ack,
    input  logic                    master_request_complete,
    input  logic [3:0]              master_request_tag,
    input  logic [6:0]              master_request_error,
    output logic [4:0]              outstanding,
    output logic                    err_dup_tag,
    output logic                    err_unknown_tag
);

    localparam int             IDX_W    = $clog2(NUM_REQ);
    localparam int             NUM_TAGS = 16;
    localparam logic [4:0]     MAX_CNT  = 5'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] eligible;

    logic [NUM_TAGS-1:0] tag_vld;
    logic [IDX_W-1:0]    tag_owner [NUM_TAGS];

    logic               grant_en;
    logic               ack_en;
    logic               cpl_hit;
    logic               cpl_miss;
    logic               dup_hit;
    logic [IDX_W-1:0]   cpl_owner;

    // In-flight counter update, clamped to [0, MAX_CNT] as a guard against
    // an inconsistent SoC-IT (e.g. duplicate tags leaving orphaned counts).
    function automatic logic [4:0] next_count(input logic [4:0] cur,
                                              input logic       inc,
                                              input logic       dec);
        logic [4:0] res;
        res = cur;
        if (inc && !dec) begin
            res = (cur >= MAX_CNT) ? MAX_CNT : cur + 5'd1;
        end else if (dec && !inc) begin
            res = (cur == 5'd0) ? 5'd0 : cur - 5'd1;
        end
        return res;
    endfunction

    // Nobody is eligible once the in-flight cap is reached; an issue that
    // was granted earlier is allowed to finish its handshake.
    assign eligible = req_valid & {NUM_REQ{outstanding < MAX_CNT}};

    // Round robin: first eligible index searching from rr_ptr+1, wrapping.
    always_comb begin : rr_search
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_found && eligible[idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[IDX_W-1:0];
            end
        end
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        ack_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_en   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (master_request_ack) begin
                    ack_en     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ack and completion share master_request_tag, so a simultaneous pair
    // always refers to the same entry: the completion retires the old owner
    // first and the ack then installs the new one, which is not a duplicate.
    assign cpl_owner = tag_owner[master_request_tag];
    assign cpl_hit   = master_request_complete &  tag_vld[master_request_tag];
    assign cpl_miss  = master_request_complete & ~tag_vld[master_request_tag];
    assign dup_hit   = ack_en & tag_vld[master_request_tag] & ~cpl_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // --- stage boundary: grant / handshake / completion registers ---
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr                       <= LAST_IDX;
            grant_idx                    <= '0;
            master_request               <= 1'b0;
            master_request_type          <= '0;
            master_request_flow          <= '0;
            master_request_local_address <= '0;
            master_request_length        <= '0;
            req_ack                      <= '0;
            req_tag                      <= '0;
            cpl_valid                    <= '0;
            cpl_tag                      <= '0;
            cpl_error                    <= '0;
            outstanding                  <= '0;
            err_dup_tag                  <= 1'b0;
            err_unknown_tag              <= 1'b0;
            tag_vld                      <= '0;
        end else begin
            req_ack   <= '0;
            cpl_valid <= '0;

            if (grant_en) begin
                grant_idx                    <= pick_idx;
                master_request               <= 1'b1;
                master_request_type          <= req_type[4*int'(pick_idx) +: 4];
                master_request_flow          <= req_flow[10*int'(pick_idx) +: 10];
                master_request_local_address <= req_local_address[64*int'(pick_idx) +: 64];
                master_request_length        <= req_length[36*int'(pick_idx) +: 36];
            end

            if (ack_en) begin
                master_request     <= 1'b0;
                req_ack[grant_idx] <= 1'b1;
                req_tag            <= master_request_tag;
                rr_ptr             <= grant_idx;
            end

            if (cpl_hit) begin
                cpl_valid[cpl_owner] <= 1'b1;
                cpl_tag              <= master_request_tag;
                cpl_error            <= master_request_error;
                tag_vld[master_request_tag] <= 1'b0;
            end

            // Placed after the completion clear so a same-tag ack wins.
            if (ack_en) begin
                tag_vld[master_request_tag] <= 1'b1;
            end

            if (dup_hit) begin
                err_dup_tag <= 1'b1;
            end
            if (cpl_miss) begin
                err_unknown_tag <= 1'b1;
            end

            outstanding <= next_count(outstanding, ack_en, cpl_hit);
        end
    end

    // Owner field is only meaningful while tag_vld is set, so it needs no
    // reset; clearing tag_vld discards the table.
    always_ff @(posedge clk) begin
        if (ack_en) begin
            tag_owner[master_request_tag] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_soc_it_master_request_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for soc_it_master_request_arbiter (NUM_REQ=4, MAX_OUTSTANDING=2).
// Stimulus pushes expected grants, acks, completions and status snapshots
// into queues; a negedge monitor pops and compares when the DUT presents
// the corresponding output.
// ---------------------------------------------------------------------------
module tb_soc_it_master_request_arbiter;

    localparam int NR   = 4;
    localparam int MAXO = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [4*NR-1:0]   req_type;
    logic [10*NR-1:0]  req_flow;
    logic [64*NR-1:0]  req_local_address;
    logic [36*NR-1:0]  req_length;
    logic [NR-1:0]     req_ack;
    logic [3:0]        req_tag;
    logic [NR-1:0]     cpl_valid;
    logic [3:0]        cpl_tag;
    logic [6:0]        cpl_error;
    logic              master_request;
    logic [3:0]        master_request_type;
    logic [9:0]        master_request_flow;
    logic [63:0]       master_request_local_address;
    logic [35:0]       master_request_length;
    logic              master_request_ack;
    logic              master_request_complete;
    logic [3:0]        master_request_tag;
    logic [6:0]        master_request_error;
    logic [4:0]        outstanding;
    logic              err_dup_tag;
    logic              err_unknown_tag;

    logic [3:0]  rt [NR];
    logic [9:0]  rf [NR];
    logic [63:0] ra [NR];
    logic [35:0] rl [NR];

    soc_it_master_request_arbiter #(
        .NUM_REQ        (NR),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req_valid                   (req_valid),
        .req_type                    (req_type),
        .req_flow                    (req_flow),
        .req_local_address           (req_local_address),
        .req_length                  (req_length),
        .req_ack                     (req_ack),
        .req_tag                     (req_tag),
        .cpl_valid                   (cpl_valid),
        .cpl_tag                     (cpl_tag),
        .cpl_error                   (cpl_error),
        .master_request              (master_request),
        .master_request_type         (master_request_type),
        .master_request_flow         (master_request_flow),
        .master_request_local_address(master_request_local_address),
        .master_request_length       (master_request_length),
        .master_request_ack          (master_request_ack),
        .master_request_complete     (master_request_complete),
        .master_request_tag          (master_request_tag),
        .master_request_error        (master_request_error),
        .outstanding                 (outstanding),
        .err_dup_tag                 (err_dup_tag),
        .err_unknown_tag             (err_unknown_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_type          = '0;
        req_flow          = '0;
        req_local_address = '0;
        req_length        = '0;
        for (int i = 0; i < NR; i++) begin
            req_type[4*i +: 4]           = rt[i];
            req_flow[10*i +: 10]         = rf[i];
            req_local_address[64*i +: 64] = ra[i];
            req_length[36*i +: 36]       = rl[i];
        end
    end

    typedef struct packed {
        logic [3:0]  typ;
        logic [9:0]  flow;
        logic [63:0] addr;
        logic [35:0] len;
    } grant_t;

    typedef struct packed {
        logic [NR-1:0] vec;
        logic [3:0]    tag;
    } ack_t;

    typedef struct packed {
        logic [NR-1:0] vec;
        logic [3:0]    tag;
        logic [6:0]    err;
    } cpl_t;

    typedef struct packed {
        logic [4:0] cnt;
        logic       dup;
        logic       unk;
        logic       mreq;
    } stat_t;

    grant_t q_grant[$];
    ack_t   q_ack[$];
    cpl_t   q_cpl[$];
    stat_t  q_stat[$];

    int   total = 0;
    int   bad   = 0;
    logic done  = 1'b0;
    logic mreq_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int i);
        grant_t g;
        g.typ  = rt[i];
        g.flow = rf[i];
        g.addr = ra[i];
        g.len  = rl[i];
        q_grant.push_back(g);
    endtask

    task automatic push_ack(input logic [NR-1:0] vec, input logic [3:0] tag);
        ack_t a;
        a.vec = vec;
        a.tag = tag;
        q_ack.push_back(a);
    endtask

    task automatic push_cpl(input logic [NR-1:0] vec, input logic [3:0] tag, input logic [6:0] err);
        cpl_t c;
        c.vec = vec;
        c.tag = tag;
        c.err = err;
        q_cpl.push_back(c);
    endtask

    task automatic push_stat(input logic [4:0] cnt, input logic dup, input logic unk, input logic mreq);
        stat_t s;
        s.cnt  = cnt;
        s.dup  = dup;
        s.unk  = unk;
        s.mreq = mreq;
        q_stat.push_back(s);
    endtask

    task automatic wait_mreq();
        int n;
        n = 0;
        while (!master_request) begin
            if (n == 40) begin
                $display("FAIL wait_mreq: master_request=0 after 40 cycles, required 1");
                $fatal(1, "handshake timeout");
            end
            tick();
            n++;
        end
    endtask

    // Ack the pending issue after `extra` additional ISSUE cycles,
    // optionally completing the same tag in the same cycle.
    task automatic do_ack(input logic [3:0] tag, input int extra,
                          input logic with_cpl, input logic [6:0] cerr);
        wait_mreq();
        repeat (extra) tick();
        master_request_ack = 1'b1;
        master_request_tag = tag;
        if (with_cpl) begin
            master_request_complete = 1'b1;
            master_request_error    = cerr;
        end
        tick();
        master_request_ack      = 1'b0;
        master_request_complete = 1'b0;
        master_request_tag      = '0;
        master_request_error    = '0;
    endtask

    task automatic do_cpl(input logic [3:0] tag, input logic [6:0] err);
        master_request_complete = 1'b1;
        master_request_tag      = tag;
        master_request_error    = err;
        tick();
        master_request_complete = 1'b0;
        master_request_tag      = '0;
        master_request_error    = '0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        ack_t   a;
        cpl_t   c;
        grant_t g;
        stat_t  s;
        if (req_ack != '0) begin
            if (q_ack.size() == 0) begin
                check("ack_unexpected", 64'(req_ack), 64'h0);
            end else begin
                a = q_ack.pop_front();
                check("ack_vec", 64'(req_ack), 64'(a.vec));
                check("ack_tag", 64'(req_tag), 64'(a.tag));
            end
        end
        if (cpl_valid != '0) begin
            if (q_cpl.size() == 0) begin
                check("cpl_unexpected", 64'(cpl_valid), 64'h0);
            end else begin
                c = q_cpl.pop_front();
                check("cpl_vec", 64'(cpl_valid), 64'(c.vec));
                check("cpl_tag", 64'(cpl_tag), 64'(c.tag));
                check("cpl_err", 64'(cpl_error), 64'(c.err));
            end
        end
        if (master_request && !mreq_prev) begin
            if (q_grant.size() == 0) begin
                check("grant_unexpected", 64'(master_request), 64'h0);
            end else begin
                g = q_grant.pop_front();
                check("grant_type", 64'(master_request_type), 64'(g.typ));
                check("grant_flow", 64'(master_request_flow), 64'(g.flow));
                check("grant_addr", master_request_local_address, g.addr);
                check("grant_len", 64'(master_request_length), 64'(g.len));
            end
        end
        mreq_prev = master_request;
        if (q_stat.size() != 0) begin
            s = q_stat.pop_front();
            check("outstanding", 64'(outstanding), 64'(s.cnt));
            check("err_dup_tag", 64'(err_dup_tag), 64'(s.dup));
            check("err_unknown_tag", 64'(err_unknown_tag), 64'(s.unk));
            check("master_request", 64'(master_request), 64'(s.mreq));
        end
        if (done) begin
            check("grants_left", 64'(q_grant.size()), 64'h0);
            check("acks_left", 64'(q_ack.size()), 64'h0);
            check("cpls_left", 64'(q_cpl.size()), 64'h0);
            check("stats_left", 64'(q_stat.size()), 64'h0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                     = 1'b0;
        req_valid               = '0;
        master_request_ack      = 1'b0;
        master_request_complete = 1'b0;
        master_request_tag      = '0;
        master_request_error    = '0;
        for (int i = 0; i < NR; i++) begin
            rt[i] = 4'(8 + i);
            rf[i] = 10'(10'h100 + i);
            ra[i] = 64'hA000_0000_0000_0000 + 64'(i) * 64'h1000;
            rl[i] = 36'(i + 1) * 36'h100;
        end

        // Reset state
        tick();
        tick();
        push_stat(5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Fairness: all valid, immediate acks with tags 0..7
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = k % NR;
            push_grant(i);
            push_ack(NR'(1 << i), 4'(k));
            do_ack(4'(k), 0, 1'b0, 7'h0);
            if (k == 7) req_valid = '0;
            push_stat(5'd1, 1'b0, 1'b0, 1'b0);
            push_cpl(NR'(1 << i), 4'(k), 7'(k + 16));
            do_cpl(4'(k), 7'(k + 16));
            push_stat(5'd0, 1'b0, 1'b0, k != 7);
        end

        // Single request from requester 2, acked after 3 ISSUE cycles
        rt[2] = 4'h1;
        rl[2] = 36'h40;
        rf[2] = 10'h2A;
        ra[2] = 64'h0000_0000_0000_2000;
        req_valid = 4'b0100;
        push_grant(2);
        push_ack(4'b0100, 4'd5);
        tick();
        push_stat(5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        push_stat(5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        push_stat(5'd0, 1'b0, 1'b0, 1'b1);
        master_request_ack = 1'b1;
        master_request_tag = 4'd5;
        tick();
        master_request_ack = 1'b0;
        master_request_tag = '0;
        req_valid = '0;
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        push_cpl(4'b0100, 4'd5, 7'd0);
        do_cpl(4'd5, 7'd0);
        push_stat(5'd0, 1'b0, 1'b0, 1'b0);

        // Cap: three requesters, only two issue until a completion
        req_valid = 4'b0111;
        push_grant(0);
        push_ack(4'b0001, 4'd1);
        do_ack(4'd1, 0, 1'b0, 7'h0);
        req_valid[0] = 1'b0;
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        push_grant(1);
        push_ack(4'b0010, 4'd2);
        do_ack(4'd2, 0, 1'b0, 7'h0);
        req_valid[1] = 1'b0;
        push_stat(5'd2, 1'b0, 1'b0, 1'b0);
        push_grant(2);
        repeat (4) begin
            tick();
            push_stat(5'd2, 1'b0, 1'b0, 1'b0);
        end
        push_cpl(4'b0001, 4'd1, 7'd0);
        do_cpl(4'd1, 7'd0);
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        push_stat(5'd1, 1'b0, 1'b0, 1'b1);
        push_ack(4'b0100, 4'd4);
        do_ack(4'd4, 0, 1'b0, 7'h0);
        req_valid[2] = 1'b0;
        push_stat(5'd2, 1'b0, 1'b0, 1'b0);
        push_cpl(4'b0010, 4'd2, 7'd0);
        do_cpl(4'd2, 7'd0);
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        push_cpl(4'b0100, 4'd4, 7'h11);
        do_cpl(4'd4, 7'h11);
        push_stat(5'd0, 1'b0, 1'b0, 1'b0);

        // Simultaneous ack and completion on tag 3
        req_valid = 4'b0001;
        push_grant(0);
        push_ack(4'b0001, 4'd3);
        do_ack(4'd3, 0, 1'b0, 7'h0);
        req_valid = '0;
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0010;
        push_grant(1);
        push_ack(4'b0010, 4'd3);
        push_cpl(4'b0001, 4'd3, 7'h05);
        do_ack(4'd3, 0, 1'b1, 7'h05);
        req_valid = '0;
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        push_cpl(4'b0010, 4'd3, 7'd0);
        do_cpl(4'd3, 7'd0);
        push_stat(5'd0, 1'b0, 1'b0, 1'b0);

        // Errors: unknown tag, then duplicate tag
        do_cpl(4'd9, 7'd0);
        push_stat(5'd0, 1'b0, 1'b1, 1'b0);
        req_valid = 4'b1000;
        push_grant(3);
        push_ack(4'b1000, 4'd2);
        do_ack(4'd2, 0, 1'b0, 7'h0);
        req_valid = '0;
        push_stat(5'd1, 1'b0, 1'b1, 1'b0);
        req_valid = 4'b0001;
        push_grant(0);
        push_ack(4'b0001, 4'd2);
        do_ack(4'd2, 0, 1'b0, 7'h0);
        req_valid = '0;
        push_stat(5'd2, 1'b1, 1'b1, 1'b0);
        push_cpl(4'b0001, 4'd2, 7'd0);
        do_cpl(4'd2, 7'd0);
        push_stat(5'd1, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of an ISSUE
        req_valid = 4'b0010;
        push_grant(1);
        wait_mreq();
        tick();
        rst = 1'b0;
        push_stat(5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 4'b1111;
        push_grant(0);
        rst = 1'b1;
        push_ack(4'b0001, 4'd6);
        do_ack(4'd6, 0, 1'b0, 7'h0);
        req_valid = '0;
        push_stat(5'd1, 1'b0, 1'b0, 1'b0);
        do_cpl(4'd2, 7'd0);
        push_stat(5'd1, 1'b0, 1'b1, 1'b0);
        push_cpl(4'b0001, 4'd6, 7'd0);
        do_cpl(4'd6, 7'd0);
        push_stat(5'd0, 1'b0, 1'b1, 1'b0);

        tick();
        tick();
        done = 1'b1;
    end

endmodule

// File: doc/soc_it_master_request_arbiter.md
# soc_it_master_request_arbiter

Shares the single SoC-IT master request port among NUM_REQ on-chip requesters, such as matching engines and descriptor fetchers. It performs round-robin arbitration, presents the granted request to the BFM/SoC-IT master request interface and captures the returned tag. It keeps a tag-ownership table so each completion and error is routed back to the requester that issued it. It sits between the application engines and the master request ports of the SoC-IT top.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_OUTSTANDING, 8, global cap on in-flight requests (1..16)

Ports:
- clk  in  1  single clock (same domain as master_clk)
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_type  in  4*NUM_REQ  packed request type, slice i for requester i
- req_flow  in  10*NUM_REQ  packed flow id
- req_local_address  in  64*NUM_REQ  packed local address
- req_length  in  36*NUM_REQ  packed length
- req_ack  out  NUM_REQ  one-cycle pulse: requester i's request accepted by SoC-IT
- req_tag  out  4  tag assigned, valid with any req_ack bit
- cpl_valid  out  NUM_REQ  one-cycle pulse: completion for requester i
- cpl_tag  out  4  completed tag, valid with cpl_valid
- cpl_error  out  7  error code of completion, valid with cpl_valid
- master_request  out  1  to SoC-IT, held until master_request_ack
- master_request_type / _flow / _local_address / _length  out  4/10/64/36  registered fields of granted request
- master_request_ack  in  1  SoC-IT accepts; master_request_tag valid this cycle
- master_request_complete  in  1  completion pulse; master_request_tag identifies the completed request
- master_request_tag  in  4  tag from SoC-IT
- master_request_error  in  7  error, valid with complete
- outstanding  out  5  current in-flight count
- err_dup_tag  out  1  sticky: ack returned a tag already in use
- err_unknown_tag  out  1  sticky: completion for a tag not in use

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: eligible = req_valid & (outstanding < MAX_OUTSTANDING). If any bit is eligible, pick the first set index searching from rr_ptr+1 modulo NUM_REQ. Register that requester's fields into the master_request_* outputs, set grant index g, go to ISSUE.
- ISSUE: master_request=1, fields held stable. On master_request_ack:
  - tag_table[master_request_tag] = {valid=1, owner=g}
  - req_ack[g] pulses; req_tag = master_request_tag
  - rr_ptr = g; outstanding += 1; go to IDLE
- Requesters hold req_valid and their fields until req_ack. Fields are sampled at grant only; later changes are ignored. Dropping req_valid after grant does not cancel the request.
- Completion, processed in any state: on master_request_complete with tag t:
  - If tag_table[t].valid: cpl_valid[owner] pulses, cpl_tag=t, cpl_error=master_request_error, entry cleared, outstanding -= 1.
  - Otherwise: no cpl_valid, err_unknown_tag set.
- Ack with a tag whose entry is valid: err_dup_tag set, entry overwritten with the new owner, outstanding still increments.
- Simultaneous ack and complete in the same cycle:
  - Both are processed; outstanding changes by +1-1=0.
  - If both carry the same tag, the completion applies to the existing entry first, then the ack installs the new one. No dup error is raised.
- Sticky errors clear only on reset.
- outstanding never exceeds MAX_OUTSTANDING. With outstanding==MAX_OUTSTANDING no grant occurs; an ISSUE already in progress still completes.

## Timing
- Reset values: all outputs 0; rr_ptr=NUM_REQ-1, so requester 0 has first priority; tag table cleared; FSM in IDLE.
- Grant latency: req_valid seen in IDLE at cycle N gives master_request=1 at cycle N+1.
- req_ack pulses in the cycle after master_request_ack is sampled. master_request drops that same cycle.
- Minimum issue spacing is 2 cycles (IDLE, ISSUE) when ack is returned in the first ISSUE cycle.
- Completion latency: cpl_valid pulses 1 cycle after master_request_complete (registered).
- Reset asserted mid-ISSUE drops master_request asynchronously and discards all table state.
- Arbitration is fair: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.

## Test plan
- Single request: req_valid[2]=1, type=4'h1, length=36'h40. SoC-IT acks after 3 cycles with tag 5 -> master_request high for 3 cycles with matching fields; req_ack=4'b0100, req_tag=5; outstanding=1. Complete tag 5, error 0 -> cpl_valid=4'b0100, cpl_tag=5; outstanding=0.
- Fairness: all 4 requesters valid, immediate ack with tags 0..7 -> grant order 0,1,2,3,0,1,2,3; each completion routed to the correct owner.
- Cap: MAX_OUTSTANDING=2, three requesters valid, no completions -> exactly 2 issued; third issues within 2 cycles of the first completion.
- Simultaneous: ack tag 3 for requester 1 while completing tag 3 owned by requester 0 -> cpl_valid=4'b0001, then tag 3 owned by requester 1; outstanding unchanged; no error flags.
- Errors: complete tag 9 with no owner -> err_unknown_tag=1 and no cpl_valid. Ack tag 2 while tag 2 is valid -> err_dup_tag=1.
- Reset during ISSUE (rst low mid-handshake) -> master_request=0 immediately, outstanding=0, table empty; requester 0 granted first afterwards.
